// File: rtl/wb_rr_arbiter.sv
// Two-requester Wishbone round-robin arbiter with registered grants and a 1-cycle hand-over gap.
// Optional per-transfer watchdog: define WB_RR_ARBITER_TIMEOUT_EN.
module wb_rr_arbiter #(
    parameter int          ADR_WIDTH          = 17,
    parameter int          TIMEOUT_CYCLES     = 15,
    parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_N_i,

    input  logic                 M0_CYC_i,
    input  logic                 M0_STB_i,
    input  logic                 M0_WE_i,
    input  logic [ADR_WIDTH-1:0] M0_ADR_i,
    input  logic [3:0]           M0_BYTE_STB_i,
    input  logic [31:0]          M0_WR_DAT_i,
    output logic [31:0]          M0_RD_DAT_o,
    output logic                 M0_ACK_o,
    output logic                 M0_ERR_o,
    output logic                 M0_GNT_o,

    input  logic                 M1_CYC_i,
    input  logic                 M1_STB_i,
    input  logic                 M1_WE_i,
    input  logic [ADR_WIDTH-1:0] M1_ADR_i,
    input  logic [3:0]           M1_BYTE_STB_i,
    input  logic [31:0]          M1_WR_DAT_i,
    output logic [31:0]          M1_RD_DAT_o,
    output logic                 M1_ACK_o,
    output logic                 M1_ERR_o,
    output logic                 M1_GNT_o,

    output logic                 WBs_CYC_o,
    output logic                 WBs_STB_o,
    output logic                 WBs_WE_o,
    output logic                 WBs_RD_o,
    output logic [ADR_WIDTH-1:0] WBs_ADR_o,
    output logic [3:0]           WBs_BYTE_STB_o,
    output logic [31:0]          WBs_WR_DAT_o,
    input  logic [31:0]          WBs_RD_DAT_i,
    input  logic                 WBs_ACK_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_rr_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] gnt_q, gnt_d;
    logic       req0, req1;
    logic       tmo;

    assign req0 = M0_CYC_i & M0_STB_i;
    assign req1 = M1_CYC_i & M1_STB_i;

    // Owners only ever release to IDLE, which guarantees the dead cycle between owners.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                    last_d  = ~last_q;
                end else if (req0) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0:    if (!M0_CYC_i) state_d = IDLE;
            OWN1:    if (!M1_CYC_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        gnt_d = {state_d == OWN1, state_d == OWN0};
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_N_i) begin
        if (!WBs_RST_N_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

    assign M0_GNT_o = gnt_q[0];
    assign M1_GNT_o = gnt_q[1];

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       own_stb;

    // tmo fires on the TIMEOUT_CYCLES-th consecutive strobe cycle without ACK; a real ACK wins.
    always_comb begin
        own_stb = ((state_q == OWN0) & M0_STB_i) | ((state_q == OWN1) & M1_STB_i);
        tmo     = own_stb & ~WBs_ACK_i & (cnt_q == 8'(TIMEOUT_CYCLES - 1));
        cnt_d   = cnt_q;
        if (state_q == IDLE || WBs_ACK_i || tmo) cnt_d = 8'd0;
        else if (own_stb)                        cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_N_i) begin
        if (!WBs_RST_N_i) cnt_q <= 8'd0;
        else              cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    // Bus mux keys off state_q so an async reset clears the bus in the same cycle.
    always_comb begin
        WBs_CYC_o      = 1'b0;
        WBs_STB_o      = 1'b0;
        WBs_WE_o       = 1'b0;
        WBs_RD_o       = 1'b0;
        WBs_ADR_o      = '0;
        WBs_BYTE_STB_o = 4'h0;
        WBs_WR_DAT_o   = 32'h0;
        M0_ACK_o       = 1'b0;
        M0_ERR_o       = 1'b0;
        M0_RD_DAT_o    = 32'h0;
        M1_ACK_o       = 1'b0;
        M1_ERR_o       = 1'b0;
        M1_RD_DAT_o    = 32'h0;
        unique case (state_q)
            OWN0: begin
                WBs_CYC_o      = M0_CYC_i;
                WBs_STB_o      = M0_STB_i & ~tmo;
                WBs_WE_o       = M0_WE_i;
                WBs_RD_o       = M0_STB_i & ~M0_WE_i & ~tmo;
                WBs_ADR_o      = M0_ADR_i;
                WBs_BYTE_STB_o = M0_BYTE_STB_i;
                WBs_WR_DAT_o   = M0_WR_DAT_i;
                M0_ACK_o       = WBs_ACK_i | tmo;
                M0_ERR_o       = tmo;
                M0_RD_DAT_o    = tmo ? DEFAULT_READ_VALUE : WBs_RD_DAT_i;
            end
            OWN1: begin
                WBs_CYC_o      = M1_CYC_i;
                WBs_STB_o      = M1_STB_i & ~tmo;
                WBs_WE_o       = M1_WE_i;
                WBs_RD_o       = M1_STB_i & ~M1_WE_i & ~tmo;
                WBs_ADR_o      = M1_ADR_i;
                WBs_BYTE_STB_o = M1_BYTE_STB_i;
                WBs_WR_DAT_o   = M1_WR_DAT_i;
                M1_ACK_o       = WBs_ACK_i | tmo;
                M1_ERR_o       = tmo;
                M1_RD_DAT_o    = tmo ? DEFAULT_READ_VALUE : WBs_RD_DAT_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios then random traffic against an ownership model.
module tb_wb_rr_arbiter;
  localparam int          AW  = 17;
  localparam int          T   = 15;
  localparam logic [31:0] DEF = 32'hBAD_FAB_AC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]           cyc, stb, we;
  logic [1:0][AW-1:0]   adr;
  logic [1:0][3:0]      bs;
  logic [1:0][31:0]     wd;
  logic [31:0]          s_rd;
  logic                 s_ack;

  logic [31:0]   rd0, rd1;
  logic          ack0, ack1, err0, err1, gnt0, gnt1;
  logic          b_cyc, b_stb, b_we, b_rd;
  logic [AW-1:0] b_adr;
  logic [3:0]    b_bs;
  logic [31:0]   b_wd;

  wb_rr_arbiter #(.ADR_WIDTH(AW), .TIMEOUT_CYCLES(T), .DEFAULT_READ_VALUE(DEF)) dut (
    .WBs_CLK_i(clk), .WBs_RST_N_i(rst_n),
    .M0_CYC_i(cyc[0]), .M0_STB_i(stb[0]), .M0_WE_i(we[0]), .M0_ADR_i(adr[0]),
    .M0_BYTE_STB_i(bs[0]), .M0_WR_DAT_i(wd[0]),
    .M0_RD_DAT_o(rd0), .M0_ACK_o(ack0), .M0_ERR_o(err0), .M0_GNT_o(gnt0),
    .M1_CYC_i(cyc[1]), .M1_STB_i(stb[1]), .M1_WE_i(we[1]), .M1_ADR_i(adr[1]),
    .M1_BYTE_STB_i(bs[1]), .M1_WR_DAT_i(wd[1]),
    .M1_RD_DAT_o(rd1), .M1_ACK_o(ack1), .M1_ERR_o(err1), .M1_GNT_o(gnt1),
    .WBs_CYC_o(b_cyc), .WBs_STB_o(b_stb), .WBs_WE_o(b_we), .WBs_RD_o(b_rd),
    .WBs_ADR_o(b_adr), .WBs_BYTE_STB_o(b_bs), .WBs_WR_DAT_o(b_wd),
    .WBs_RD_DAT_i(s_rd), .WBs_ACK_i(s_ack)
  );

  int ncmp = 0;
  int nfail = 0;

  // reference: owner -1 = nobody, 0/1 = requester; last = requester served last
  int own  = -1;
  int last = 1;
  int wrun = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag);
    logic tmo;
    tmo = 1'b0;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
    if (own >= 0) tmo = stb[own] && !s_ack && (wrun == T - 1);
`endif
    if (own < 0) begin
      chk({tag, ":cyc"}, b_cyc, 0);
      chk({tag, ":stb"}, b_stb, 0);
      chk({tag, ":bus"}, {b_we, b_rd, b_adr, b_bs}, 0);
      chk({tag, ":wd"}, b_wd, 0);
    end else begin
      chk({tag, ":cyc"}, b_cyc, cyc[own]);
      chk({tag, ":stb"}, b_stb, stb[own] & ~tmo);
      chk({tag, ":we"}, b_we, we[own]);
      chk({tag, ":rd"}, b_rd, stb[own] & ~we[own] & ~tmo);
      chk({tag, ":adr"}, b_adr, adr[own]);
      chk({tag, ":bs"}, b_bs, bs[own]);
      chk({tag, ":wd"}, b_wd, wd[own]);
    end
    chk({tag, ":gnt0"}, gnt0, own == 0);
    chk({tag, ":gnt1"}, gnt1, own == 1);
    chk({tag, ":ack0"}, ack0, (own == 0) ? (s_ack | tmo) : 1'b0);
    chk({tag, ":ack1"}, ack1, (own == 1) ? (s_ack | tmo) : 1'b0);
    chk({tag, ":err0"}, err0, (own == 0) && tmo);
    chk({tag, ":err1"}, err1, (own == 1) && tmo);
    chk({tag, ":rdat0"}, rd0, (own == 0) ? (tmo ? DEF : s_rd) : 32'h0);
    chk({tag, ":rdat1"}, rd1, (own == 1) ? (tmo ? DEF : s_rd) : 32'h0);
  endtask

  task automatic model_edge();
    logic r0, r1;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
    if (own < 0 || s_ack) wrun = 0;
    else if (stb[own]) wrun = (wrun == T - 1) ? 0 : wrun + 1;
`endif
    r0 = cyc[0] & stb[0];
    r1 = cyc[1] & stb[1];
    if (own < 0) begin
      if (r0 && r1) own = (last == 1) ? 0 : 1;
      else if (r0) own = 0;
      else if (r1) own = 1;
      if (own >= 0) last = own;
    end else if (!cyc[own]) begin
      own = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input string tag);
    #3;
    check_cycle(tag);
    tick();
  endtask

  task automatic idle_inputs();
    cyc = '0; stb = '0; we = '0; adr = '0; bs = '0; wd = '0;
    s_ack = 1'b0; s_rd = 32'h0;
  endtask

  task automatic model_reset();
    own = -1; last = 1; wrun = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic drive_random();
    for (int n = 0; n < 2; n++) begin
      if (cyc[n]) cyc[n] = ($urandom_range(0, 9) < 8);
      else        cyc[n] = ($urandom_range(0, 9) < 3);
      stb[n] = cyc[n] ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 1);
      we[n]  = 1'($urandom);
      adr[n] = AW'($urandom);
      bs[n]  = 4'($urandom);
      wd[n]  = $urandom;
    end
    s_ack = ($urandom_range(0, 9) < 4);
    s_rd  = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, with requests already pending and a stray ACK
    idle_inputs();
    cyc = 2'b11; stb = 2'b11;
    @(posedge clk); #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_cyc", b_cyc, 0);
    chk("rst_stb", b_stb, 0);
    s_ack = 1'b1; #1;
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    do_reset();

    // single requester read: CYC rises one edge after the request, ACK two cycles after STB
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 17'h00014; bs[0] = 4'hF;
    #3; chk("r031_cyc_before", b_cyc, 0); check_cycle("r031_req"); tick();
    #3; chk("r031_cyc_rise", b_cyc, 1); chk("r031_adr", b_adr, 17'h00014);
    chk("r031_rd", b_rd, 1); check_cycle("r031_stb"); tick();
    step("r031_wait");
    s_ack = 1; s_rd = 32'h0000_1234;
    #3; chk("r031_rdat0", rd0, 32'h0000_1234); chk("r031_ack0", ack0, 1);
    chk("r031_rdat1", rd1, 0); chk("r031_ack1", ack1, 0);
    check_cycle("r031_ack"); tick();
    s_ack = 0; s_rd = 0; cyc[0] = 0; stb[0] = 0;
    step("r031_drop");
    step("r031_idle");

    // tie after reset: M0 first, one dead cycle, then M1, next tie back to M0
    do_reset();
    cyc = 2'b11; stb = 2'b11;
    step("r032_tie1");
    #3; chk("r032_gnt0_first", gnt0, 1); chk("r032_gnt1_first", gnt1, 0);
    check_cycle("r032_own0"); tick();
    cyc[0] = 0; stb[0] = 0;
    step("r032_rel0");
    #3; chk("r032_dead_gnt0", gnt0, 0); chk("r032_dead_gnt1", gnt1, 0);
    check_cycle("r032_dead"); tick();
    #3; chk("r032_gnt1_second", gnt1, 1); check_cycle("r032_own1"); tick();
    cyc = 2'b01; stb = 2'b01;
    step("r032_rel1");
    cyc = 2'b11; stb = 2'b11;
    step("r032_tie2");
    #3; chk("r032_gnt0_third", gnt0, 1); chk("r032_gnt1_third", gnt1, 0);
    check_cycle("r032_own0b"); tick();
    idle_inputs();
    step("r032_rel");
    step("r032_end");

    // locked burst: M1 holds CYC across 4 writes while M0 keeps requesting
    do_reset();
    cyc[1] = 1; stb[1] = 1; we[1] = 1; bs[1] = 4'hF; adr[1] = 17'h00100;
    step("r033_req1");
    cyc[0] = 1; stb[0] = 1;
    for (int k = 1; k <= 4; k++) begin
      wd[1] = 32'(k); adr[1] = 17'h00100 + AW'(4 * k); s_ack = 1;
      #3; chk("r033_wdat", b_wd, 32'(k)); chk("r033_we", b_we, 1);
      chk("r033_gnt0_held", gnt0, 0); chk("r033_gnt1", gnt1, 1);
      check_cycle("r033_burst"); tick();
    end
    cyc[1] = 0; stb[1] = 0; s_ack = 0;
    step("r033_rel");
    #3; chk("r033_dead_gnt0", gnt0, 0); check_cycle("r033_dead"); tick();
    #3; chk("r033_gnt0_after", gnt0, 1); check_cycle("r033_own0"); tick();
    idle_inputs();
    step("r033_end");

    // unresponsive slave
    do_reset();
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 17'h1FFFC;
    step("r034_req");
`ifdef WB_RR_ARBITER_TIMEOUT_EN
    for (int i = 1; i <= T; i++) begin
      #3;
      if (i == T) begin
        chk("r034_tmo_ack", ack0, 1); chk("r034_tmo_err", err0, 1);
        chk("r034_tmo_rdat", rd0, DEF); chk("r034_tmo_stb", b_stb, 0);
      end else begin
        chk("r034_wait_ack", ack0, 0);
      end
      check_cycle("r034_wait"); tick();
    end
`else
    for (int i = 0; i < 100; i++) step("r034_noack");
    #3; chk("r034_final_ack", ack0, 0); chk("r034_final_err", err0, 0);
    chk("r034_still_cyc", b_cyc, 1); check_cycle("r034_hold"); tick();
`endif
    idle_inputs();
    step("r034_end");

    // reset while M1 owns the bus with STB high
    do_reset();
    cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 17'h00040;
    step("r035_req");
    step("r035_own1");
    cyc[0] = 1; stb[0] = 1; s_ack = 1; s_rd = 32'hDEAD_0001;
    #2; chk("r035_pre_cyc", b_cyc, 1);
    rst_n = 1'b0; model_reset();
    #1; chk("r035_cyc", b_cyc, 0); chk("r035_stb", b_stb, 0);
    chk("r035_gnt1", gnt1, 0); chk("r035_ack1", ack1, 0); chk("r035_err1", err1, 0);
    @(posedge clk); #1;
    chk("r035_hold_gnt0", gnt0, 0); chk("r035_hold_gnt1", gnt1, 0);
    #2 rst_n = 1'b1; s_ack = 0;
    tick();
    #3; chk("r035_tie_gnt0", gnt0, 1); chk("r035_tie_gnt1", gnt1, 0);
    check_cycle("r035_own0"); tick();

    // random traffic
    do_reset();
    for (int c = 0; c < 500; c++) begin
      drive_random();
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 17, Wishbone byte-address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, the number of STB-without-ACK cycles before forced termination (range 1..255).
REQ-003 SHALL have parameter DEFAULT_READ_VALUE, default 32'hBAD_FAB_AC, the read data returned on a timed-out cycle.
REQ-004 SHALL have WBs_CLK_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have WBs_RST_N_i, input, 1, reset, asynchronous assert, active-low.
REQ-006 SHALL have, for each requester n = 0,1, the following inputs: Mn_CYC_i (1), Mn_STB_i (1), Mn_WE_i (1), Mn_ADR_i (ADR_WIDTH), Mn_BYTE_STB_i (4) and Mn_WR_DAT_i (32), all from requester n.
REQ-007 SHALL have, for each requester n = 0,1, the following outputs: Mn_RD_DAT_o (32), Mn_ACK_o (1), Mn_ERR_o (1) and Mn_GNT_o (1), all to requester n.
REQ-008 SHALL have the following shared-bus outputs to the slave fabric: WBs_CYC_o (1), WBs_STB_o (1), WBs_WE_o (1), WBs_RD_o (1), WBs_ADR_o (ADR_WIDTH), WBs_BYTE_STB_o (4) and WBs_WR_DAT_o (32).
REQ-009 SHALL have the following shared-bus inputs from the slave fabric: WBs_RD_DAT_i (32) and WBs_ACK_i (1).

Function
REQ-010 SHALL define the request reqn as Mn_CYC_i AND Mn_STB_i.
REQ-011 SHALL implement an FSM with states IDLE, OWN0 and OWN1, encoded in registers.
REQ-012 SHALL take these FSM transitions:
- In IDLE with exactly one reqn asserted, go to OWNn on the next edge.
- In IDLE with both requests asserted, grant the requester not served last (round-robin via a registered last-grant pointer).
- In IDLE with no request, stay in IDLE.
REQ-013 SHALL hold OWNn while Mn_CYC_i = 1, which allows back-to-back transfers, and return to IDLE on the first edge at which Mn_CYC_i = 0.
REQ-014 SHALL have one mandatory IDLE cycle between owners, so bus hand-over costs exactly 1 dead cycle.
REQ-015 SHALL make Mn_GNT_o a registered output equal to 1 exactly while the FSM is in OWNn.
REQ-016 SHALL, in OWNn, drive the shared-bus outputs combinationally from requester n, with WBs_RD_o = Mn_STB_i AND NOT Mn_WE_i.
REQ-017 SHALL, in IDLE, drive all shared-bus outputs to 0.
REQ-018 SHALL route WBs_ACK_i and WBs_RD_DAT_i only to the owning requester; the non-owner sees Mn_ACK_o = 0 and Mn_RD_DAT_o = 0.
REQ-019 SHALL have a minimum latency of 1 edge from request to WBs_CYC_o = 1, i.e. WBs_CYC_o rises in the cycle after reqn is first sampled in IDLE.
REQ-020 SHALL NOT act on a request from the non-owner during OWNn; it is serviced after release per REQ-012.
REQ-021 SHALL ignore a WBs_ACK_i that arrives while the FSM is in IDLE.
REQ-022 SHALL return to IDLE on the next edge if the owner drops Mn_CYC_i in the same cycle as WBs_ACK_i; the ACK is still passed to the owner in that cycle.
REQ-023 SHALL update the last-grant pointer on each IDLE to OWNn transition.

Reset
REQ-024 SHALL, while WBs_RST_N_i = 0, immediately (asynchronously) force the FSM to IDLE, the last-grant pointer to 1 (so requester 0 wins the first tie), the timeout counter to 0, and all Mn_GNT_o to 0.
REQ-025 SHALL, on reset asserted mid-transfer, drop WBs_CYC_o and WBs_STB_o within the same cycle and issue no ACK or ERR for the aborted transfer.
REQ-026 SHALL, on reset release, start arbitrating no earlier than the first rising edge after deassertion.

Configuration
REQ-027 SHALL, with WB_RR_ARBITER_TIMEOUT_EN defined, implement an 8-bit counter that increments each cycle the FSM is in OWNn with Mn_STB_i = 1 and WBs_ACK_i = 0, and clears on ACK, on IDLE, or on timeout.
REQ-028 SHALL, when that counter reaches TIMEOUT_CYCLES, for one cycle assert Mn_ACK_o = 1 and Mn_ERR_o = 1, drive Mn_RD_DAT_o = DEFAULT_READ_VALUE, and drive WBs_STB_o = 0.
REQ-029 SHALL give precedence to a real WBs_ACK_i arriving in that same cycle, so no ERR is raised.
REQ-030 SHALL, without WB_RR_ARBITER_TIMEOUT_EN, tie Mn_ERR_o to 0 and omit the counter, so an unacknowledged cycle holds the bus indefinitely.

Verification
REQ-031 SHALL cover single requester: M0 read, addr 17'h00014, slave ACKs 2 cycles after STB with data 32'h0000_1234 -> WBs_CYC_o rises 1 cycle after request, M0_RD_DAT_o = 32'h0000_1234 with M0_ACK_o, M1 sees 0.
REQ-032 SHALL cover a tie: both requesters assert in the same cycle after reset -> M0 granted first; after M0 drops CYC, 1 IDLE cycle, then M1 granted; the next simultaneous tie grants M0.
REQ-033 SHALL cover a locked burst: M1 holds CYC for 4 writes (data 32'h1..32'h4) while M0 requests -> M0_GNT_o stays 0 until M1 drops CYC; all 4 writes appear on the shared bus in order.
REQ-034 SHALL cover timeout (macro on, TIMEOUT_CYCLES = 15): M0 read to an unresponsive slave -> at the 15th wait cycle M0_ACK_o = M0_ERR_o = 1 and M0_RD_DAT_o = 32'hBAD_FAB_AC; with the macro off, no ACK after 100 cycles.
REQ-035 SHALL cover reset mid-transfer: assert WBs_RST_N_i = 0 while the FSM is in OWN1 with STB high -> WBs_CYC_o = 0 in the same cycle, M1_GNT_o = 0, no ACK; after release, a tie goes to M0.
